// File: rtl/gcd_controller.sv
// Subtractive GCD controller driving an external comparator; x/y/gcd_out registered, done/error pulsed.
// Optional iteration counter output iter_count enabled by defining GCD_ITER_COUNT_EN.
module gcd_controller #(
  parameter int number_width = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [number_width-1:0] x_in,
  input  logic [number_width-1:0] y_in,
  output logic [number_width-1:0] comp1,
  output logic [number_width-1:0] comp2,
  input  logic [1:0]              compare_result,
  output logic                    ready,
  output logic                    done,
  output logic                    error,
  output logic [number_width-1:0] gcd_out
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [number_width-1:0] iter_count
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  localparam logic [1:0] CMP_GT = 2'd0;
  localparam logic [1:0] CMP_LT = 2'd1;
  localparam logic [1:0] CMP_EQ = 2'd2;

  state_t                  state, state_nxt;
  logic [number_width-1:0] x_r, x_nxt;
  logic [number_width-1:0] y_r, y_nxt;
  logic [number_width-1:0] gcd_r, gcd_nxt;
  logic                    done_r, done_nxt;
  logic                    error_r, error_nxt;

  // Modular difference: the larger operand is always the minuend, so no borrow is kept.
  function automatic logic [number_width-1:0] sub_wrap(
    input logic [number_width-1:0] a,
    input logic [number_width-1:0] b
  );
    return a - b;
  endfunction

`ifdef GCD_ITER_COUNT_EN
  logic [number_width-1:0] cnt_r, cnt_nxt;

  function automatic logic [number_width-1:0] sat_inc(
    input logic [number_width-1:0] v
  );
    if (v == {number_width{1'b1}}) return v;
    return v + {{(number_width-1){1'b0}}, 1'b1};
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    x_nxt     = x_r;
    y_nxt     = y_r;
    gcd_nxt   = gcd_r;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
`ifdef GCD_ITER_COUNT_EN
    cnt_nxt   = cnt_r;
`endif
    case (state)
      IDLE: begin
        if (start) begin
`ifdef GCD_ITER_COUNT_EN
          cnt_nxt = '0;
`endif
          if ((x_in != '0) && (y_in != '0)) begin
            x_nxt     = x_in;
            y_nxt     = y_in;
            state_nxt = COMPARE;
          end else begin
            // A zero operand makes the other one the answer; gcd(0,0) falls out as 0.
            gcd_nxt  = x_in | y_in;
            done_nxt = 1'b1;
          end
        end
      end
      COMPARE: begin
        case (compare_result)
          CMP_GT: begin
            x_nxt = sub_wrap(x_r, y_r);
`ifdef GCD_ITER_COUNT_EN
            cnt_nxt = sat_inc(cnt_r);
`endif
          end
          CMP_LT: begin
            y_nxt = sub_wrap(y_r, x_r);
`ifdef GCD_ITER_COUNT_EN
            cnt_nxt = sat_inc(cnt_r);
`endif
          end
          CMP_EQ: begin
            gcd_nxt   = x_r;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
          default: begin
            done_nxt  = 1'b1;
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r     <= '0;
      y_r     <= '0;
      gcd_r   <= '0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      x_r     <= x_nxt;
      y_r     <= y_nxt;
      gcd_r   <= gcd_nxt;
      done_r  <= done_nxt;
      error_r <= error_nxt;
    end
  end

`ifdef GCD_ITER_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt;
    end
  end

  assign iter_count = cnt_r;
`endif

  assign comp1   = x_r;
  assign comp2   = y_r;
  assign ready   = (state == IDLE);
  assign done    = done_r;
  assign error   = error_r;
  assign gcd_out = gcd_r;

endmodule
